// File: rtl/multicycle_control_if.sv
// Handshake and strobe bundle between the multi-cycle sequencer and the RV32I datapath.
interface multicycle_control_if #(
    parameter int unsigned CNT_W = 32
);
    logic [6:0]       op;
    logic             mem_ready;
    logic             branch_taken;
    logic             mem_read;
    logic             mem_write;
    logic             addr_sel;
    logic             ir_write;
    logic             reg_write;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic [2:0]       state;
    logic             trap;
    logic [1:0]       trap_cause;
    logic [CNT_W-1:0] instret;

    // Sequencer side: consumes opcode and memory/ALU status, drives strobes.
    modport master (
        input  op, mem_ready, branch_taken,
        output mem_read, mem_write, addr_sel, ir_write, reg_write, pc_write,
        output pc_src, state, trap, trap_cause, instret
    );

    // Datapath side: supplies opcode and status, obeys strobes.
    modport slave (
        output op, mem_ready, branch_taken,
        input  mem_read, mem_write, addr_sel, ir_write, reg_write, pc_write,
        input  pc_src, state, trap, trap_cause, instret
    );
endinterface

// File: rtl/multicycle_control.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I core with memory timeout,
// illegal-opcode trap and retired-instruction counter.
module multicycle_control #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input logic                  clk,
    input logic                  rst,
    multicycle_control_if.master bus
);
    localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_IMM  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [6:0]       op_q;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0] instret_q;
    logic             trap_q;
    logic [1:0]       trap_cause_q, trap_cause_d;

    logic             mem_read, mem_write, addr_sel, ir_write, reg_write, pc_write;
    logic [1:0]       pc_src;
    logic             op_legal;
    logic             timeout_hit;
    logic             waiting;

    // Opcode legality check on the live IR value, used only in DECODE.
    always_comb begin
        op_legal = 1'b0;
        case (bus.op)
            OP_R, OP_I_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: op_legal = 1'b1;
            default:                           op_legal = 1'b0;
        endcase
    end

    assign waiting     = ((state_q == S_FETCH) || (state_q == S_MEM)) && !bus.mem_ready;
    assign timeout_hit = (TIMEOUT > 0) && (wait_cnt_q == WAIT_W'(TIMEOUT - 1));

    // Next-state and strobe decode; strobes are squashed while reset is held.
    always_comb begin
        state_d      = state_q;
        trap_cause_d = trap_cause_q;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        addr_sel     = 1'b0;
        ir_write     = 1'b0;
        reg_write    = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 2'd0;
        case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                if (bus.mem_ready) begin
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (timeout_hit) begin
                    state_d      = S_TRAP;
                    trap_cause_d = 2'd2;
                end
            end
            S_DECODE: begin
                if (op_legal) begin
                    state_d = S_EXEC;
                end else begin
                    state_d      = S_TRAP;
                    trap_cause_d = 2'd1;
                end
            end
            S_EXEC: begin
                if ((op_q == OP_LOAD) || (op_q == OP_STORE)) begin
                    state_d = S_MEM;
                end else if (op_q == OP_BRANCH) begin
                    pc_write = 1'b1;
                    pc_src   = bus.branch_taken ? 2'd1 : 2'd0;
                    state_d  = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                addr_sel  = 1'b1;
                mem_read  = (op_q == OP_LOAD);
                mem_write = (op_q == OP_STORE);
                if (bus.mem_ready) begin
                    if (op_q == OP_STORE) begin
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout_hit) begin
                    state_d      = S_TRAP;
                    trap_cause_d = 2'd2;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                if (op_q == OP_JAL) begin
                    pc_src = 2'd1;
                end else if (op_q == OP_JALR) begin
                    pc_src = 2'd2;
                end
                state_d = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
        if (rst) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            pc_write  = 1'b0;
        end
    end

    // State, opcode latch, wait counter, retire counter and sticky trap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_FETCH;
            op_q         <= 7'd0;
            wait_cnt_q   <= '0;
            instret_q    <= '0;
            trap_q       <= 1'b0;
            trap_cause_q <= 2'd0;
        end else begin
            state_q      <= state_d;
            trap_cause_q <= trap_cause_d;
            if (state_q == S_DECODE) begin
                op_q <= bus.op;
            end
            wait_cnt_q <= waiting ? (wait_cnt_q + WAIT_W'(1)) : '0;
            if (pc_write) begin
                instret_q <= instret_q + CNT_W'(1);
            end
            if (state_d == S_TRAP) begin
                trap_q <= 1'b1;
            end
        end
    end

    assign bus.mem_read   = mem_read;
    assign bus.mem_write  = mem_write;
    assign bus.addr_sel   = addr_sel;
    assign bus.ir_write   = ir_write;
    assign bus.reg_write  = reg_write;
    assign bus.pc_write   = pc_write;
    assign bus.pc_src     = pc_src;
    assign bus.state      = state_q;
    assign bus.trap       = trap_q;
    assign bus.trap_cause = trap_cause_q;
    assign bus.instret    = instret_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with TIMEOUT=4.
module tb_multicycle_control;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_IMM  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ILL    = 7'b1111111;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    multicycle_control_if #(.CNT_W(32)) bus ();

    multicycle_control #(.TIMEOUT(4), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {state, mem_read, mem_write, addr_sel, ir_write, reg_write, pc_write, pc_src}
    function automatic logic [10:0] mk(input logic [2:0] st, input logic rd, input logic wr,
                                       input logic as, input logic ir, input logic rw,
                                       input logic pw, input logic [1:0] src);
        return {st, rd, wr, as, ir, rw, pw, src};
    endfunction

    function automatic logic [10:0] obs_vec();
        return {bus.state, bus.mem_read, bus.mem_write, bus.addr_sel, bus.ir_write,
                bus.reg_write, bus.pc_write, bus.pc_src};
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive inputs, check decode mid-cycle, advance past the edge.
    task automatic cyc(input string tag, input logic [6:0] op_v, input logic rdy,
                       input logic bt, input logic [10:0] exp_v);
        bus.op           = op_v;
        bus.mem_ready    = rdy;
        bus.branch_taken = bt;
        @(negedge clk);
        check(tag, 32'(obs_vec()), 32'(exp_v));
        @(posedge clk);
        #1;
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        rst              = 1'b1;
        bus.op           = 7'd0;
        bus.mem_ready    = 1'b1;
        bus.branch_taken = 1'b0;

        // Reset state: FETCH with strobes forced low
        @(negedge clk);
        check("rst_vec", 32'(obs_vec()), 32'(mk(3'd0, 0, 0, 0, 0, 0, 0, 2'd0)));
        check("rst_instret", bus.instret, 32'd0);
        check("rst_trap", 32'(bus.trap), 32'd0);
        check("rst_cause", 32'(bus.trap_cause), 32'd0);
        release_rst();

        // Zero-wait ADD
        cyc("add_fetch",  OP_R, 1, 0, mk(3'd0, 1, 0, 0, 1, 0, 0, 2'd0));
        cyc("add_decode", OP_R, 0, 0, mk(3'd1, 0, 0, 0, 0, 0, 0, 2'd0));
        cyc("add_exec",   OP_R, 0, 0, mk(3'd2, 0, 0, 0, 0, 0, 0, 2'd0));
        cyc("add_wb",     OP_R, 0, 0, mk(3'd4, 0, 0, 0, 0, 1, 1, 2'd0));
        check("add_instret", bus.instret, 32'd1);

        // LOAD with two wait cycles in MEM
        cyc("ld_fetch",  OP_LOAD, 1, 0, mk(3'd0, 1, 0, 0, 1, 0, 0, 2'd0));
        cyc("ld_decode", OP_LOAD, 0, 0, mk(3'd1, 0, 0, 0, 0, 0, 0, 2'd0));
        cyc("ld_exec",   OP_LOAD, 0, 0, mk(3'd2, 0, 0, 0, 0, 0, 0, 2'd0));
        cyc("ld_mem_w0", OP_LOAD, 0, 0, mk(3'd3, 1, 0, 1, 0, 0, 0, 2'd0));
        cyc("ld_mem_w1", OP_LOAD, 0, 0, mk(3'd3, 1, 0, 1, 0, 0, 0, 2'd0));
        cyc("ld_mem_rdy", OP_LOAD, 1, 0, mk(3'd3, 1, 0, 1, 0, 0, 0, 2'd0));
        cyc("ld_wb",     OP_LOAD, 0, 0, mk(3'd4, 0, 0, 0, 0, 1, 1, 2'd0));
        check("ld_instret", bus.instret, 32'd2);

        // Zero-wait STORE retires from MEM
        cyc("st_fetch",  OP_STORE, 1, 0, mk(3'd0, 1, 0, 0, 1, 0, 0, 2'd0));
        cyc("st_decode", OP_STORE, 0, 0, mk(3'd1, 0, 0, 0, 0, 0, 0, 2'd0));
        cyc("st_exec",   OP_STORE, 0, 0, mk(3'd2, 0, 0, 0, 0, 0, 0, 2'd0));
        cyc("st_mem",    OP_STORE, 1, 0, mk(3'd3, 0, 1, 1, 0, 0, 1, 2'd0));
        check("st_instret", bus.instret, 32'd3);

        // BRANCH taken then not taken
        cyc("bt_fetch",  OP_BRANCH, 1, 0, mk(3'd0, 1, 0, 0, 1, 0, 0, 2'd0));
        cyc("bt_decode", OP_BRANCH, 0, 0, mk(3'd1, 0, 0, 0, 0, 0, 0, 2'd0));
        cyc("bt_exec",   OP_BRANCH, 0, 1, mk(3'd2, 0, 0, 0, 0, 0, 1, 2'd1));
        check("bt_instret", bus.instret, 32'd4);
        cyc("bn_fetch",  OP_BRANCH, 1, 0, mk(3'd0, 1, 0, 0, 1, 0, 0, 2'd0));
        cyc("bn_decode", OP_BRANCH, 0, 0, mk(3'd1, 0, 0, 0, 0, 0, 0, 2'd0));
        cyc("bn_exec",   OP_BRANCH, 0, 0, mk(3'd2, 0, 0, 0, 0, 0, 1, 2'd0));
        check("bn_instret", bus.instret, 32'd5);

        // JALR and JAL select their PC sources in WB
        cyc("jalr_fetch",  OP_JALR, 1, 0, mk(3'd0, 1, 0, 0, 1, 0, 0, 2'd0));
        cyc("jalr_decode", OP_JALR, 0, 0, mk(3'd1, 0, 0, 0, 0, 0, 0, 2'd0));
        cyc("jalr_exec",   OP_JALR, 0, 0, mk(3'd2, 0, 0, 0, 0, 0, 0, 2'd0));
        cyc("jalr_wb",     OP_JALR, 0, 0, mk(3'd4, 0, 0, 0, 0, 1, 1, 2'd2));
        cyc("jal_fetch",   OP_JAL, 1, 0, mk(3'd0, 1, 0, 0, 1, 0, 0, 2'd0));
        cyc("jal_decode",  OP_JAL, 0, 0, mk(3'd1, 0, 0, 0, 0, 0, 0, 2'd0));
        cyc("jal_exec",    OP_JAL, 0, 0, mk(3'd2, 0, 0, 0, 0, 0, 0, 2'd0));
        cyc("jal_wb",      OP_JAL, 0, 0, mk(3'd4, 0, 0, 0, 0, 1, 1, 2'd1));
        check("jal_instret", bus.instret, 32'd7);

        // FETCH ready arrives on the last allowed cycle; stray ready later is ignored
        cyc("nm_fetch_w0", OP_I_IMM, 0, 0, mk(3'd0, 1, 0, 0, 0, 0, 0, 2'd0));
        cyc("nm_fetch_w1", OP_I_IMM, 0, 0, mk(3'd0, 1, 0, 0, 0, 0, 0, 2'd0));
        cyc("nm_fetch_w2", OP_I_IMM, 0, 0, mk(3'd0, 1, 0, 0, 0, 0, 0, 2'd0));
        cyc("nm_fetch_rdy", OP_I_IMM, 1, 0, mk(3'd0, 1, 0, 0, 1, 0, 0, 2'd0));
        cyc("nm_decode",   OP_I_IMM, 1, 0, mk(3'd1, 0, 0, 0, 0, 0, 0, 2'd0));
        cyc("nm_exec",     OP_I_IMM, 1, 0, mk(3'd2, 0, 0, 0, 0, 0, 0, 2'd0));
        cyc("nm_wb",       OP_I_IMM, 1, 0, mk(3'd4, 0, 0, 0, 0, 1, 1, 2'd0));
        check("nm_instret", bus.instret, 32'd8);
        check("nm_trap", 32'(bus.trap), 32'd0);

        // Illegal opcode traps and stays silent
        cyc("ill_fetch",  OP_ILL, 1, 0, mk(3'd0, 1, 0, 0, 1, 0, 0, 2'd0));
        cyc("ill_decode", OP_ILL, 1, 0, mk(3'd1, 0, 0, 0, 0, 0, 0, 2'd0));
        for (int i = 0; i < 20; i++) begin
            cyc("ill_trap", OP_LOAD, 1, 1, mk(3'd7, 0, 0, 0, 0, 0, 0, 2'd0));
        end
        check("ill_trap_flag", 32'(bus.trap), 32'd1);
        check("ill_cause", 32'(bus.trap_cause), 32'd1);
        check("ill_instret", bus.instret, 32'd8);

        // Reset out of TRAP
        rst = 1'b1;
        #1;
        check("ill_rst_vec", 32'(obs_vec()), 32'(mk(3'd0, 0, 0, 0, 0, 0, 0, 2'd0)));
        check("ill_rst_instret", bus.instret, 32'd0);
        check("ill_rst_trap", 32'(bus.trap), 32'd0);
        check("ill_rst_cause", 32'(bus.trap_cause), 32'd0);
        release_rst();

        // FETCH timeout after four idle cycles
        cyc("to_fetch_w0", OP_R, 0, 0, mk(3'd0, 1, 0, 0, 0, 0, 0, 2'd0));
        cyc("to_fetch_w1", OP_R, 0, 0, mk(3'd0, 1, 0, 0, 0, 0, 0, 2'd0));
        cyc("to_fetch_w2", OP_R, 0, 0, mk(3'd0, 1, 0, 0, 0, 0, 0, 2'd0));
        cyc("to_fetch_w3", OP_R, 0, 0, mk(3'd0, 1, 0, 0, 0, 0, 0, 2'd0));
        cyc("to_trap",     OP_R, 1, 0, mk(3'd7, 0, 0, 0, 0, 0, 0, 2'd0));
        check("to_trap_flag", 32'(bus.trap), 32'd1);
        check("to_cause", 32'(bus.trap_cause), 32'd2);
        rst = 1'b1;
        release_rst();

        // Reset asserted during WB suppresses the write and clears instret
        cyc("mr0_fetch",  OP_R, 1, 0, mk(3'd0, 1, 0, 0, 1, 0, 0, 2'd0));
        cyc("mr0_decode", OP_R, 0, 0, mk(3'd1, 0, 0, 0, 0, 0, 0, 2'd0));
        cyc("mr0_exec",   OP_R, 0, 0, mk(3'd2, 0, 0, 0, 0, 0, 0, 2'd0));
        cyc("mr0_wb",     OP_R, 0, 0, mk(3'd4, 0, 0, 0, 0, 1, 1, 2'd0));
        check("mr0_instret", bus.instret, 32'd1);
        cyc("mr1_fetch",  OP_R, 1, 0, mk(3'd0, 1, 0, 0, 1, 0, 0, 2'd0));
        cyc("mr1_decode", OP_R, 0, 0, mk(3'd1, 0, 0, 0, 0, 0, 0, 2'd0));
        cyc("mr1_exec",   OP_R, 0, 0, mk(3'd2, 0, 0, 0, 0, 0, 0, 2'd0));
        #1;
        rst = 1'b1;
        #1;
        check("mr_rst_vec", 32'(obs_vec()), 32'(mk(3'd0, 0, 0, 0, 0, 0, 0, 2'd0)));
        check("mr_rst_instret", bus.instret, 32'd0);
        release_rst();
        cyc("mr_after_fetch", OP_R, 1, 0, mk(3'd0, 1, 0, 0, 1, 0, 0, 2'd0));
        check("mr_after_instret", bus.instret, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
